conv_window_gen: RTL

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen.sv | 108 ++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator for a raster pixel stream. Two line buffers supply
// the two rows above the incoming pixel; complete in-image windows are registered out.
module conv_window_gen #(
    parameter int NB_DATA     = 8,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16,
    parameter int KERNEL_SIZE = 9
) (
    input  logic                           clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    input  logic                           i_sof,
    input  logic [NB_DATA-1:0]             i_pixel,
    output logic [NB_DATA*KERNEL_SIZE-1:0] o_window,
    output logic                           o_valid
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int FW = 3 * NB_DATA;
    localparam int WW = NB_DATA * KERNEL_SIZE;

    logic [CW-1:0]      col_r;
    logic [RW-1:0]      row_r;
    logic [WW-1:0]      win_r;
    logic [WW-1:0]      o_window_r;
    logic               o_valid_r;
    logic [NB_DATA-1:0] lb1_r [IMG_WIDTH];
    logic [NB_DATA-1:0] lb2_r [IMG_WIDTH];

    logic [CW-1:0]      cur_col_s;
    logic [RW-1:0]      cur_row_s;
    logic [CW-1:0]      next_col_s;
    logic [RW-1:0]      next_row_s;
    logic [NB_DATA-1:0] lb1_rd_s;
    logic [NB_DATA-1:0] lb2_rd_s;
    logic [WW-1:0]      win_next_s;
    logic               win_ok_s;

    // Position of the pixel on the input, next position, and the shifted window.
    always_comb begin
        cur_col_s  = col_r;
        cur_row_s  = row_r;
        next_col_s = col_r;
        next_row_s = row_r;
        if (i_sof) begin
            cur_col_s = {CW{1'b0}};
            cur_row_s = {RW{1'b0}};
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
        if (cur_col_s == CW'(IMG_WIDTH - 1)) begin
            next_col_s = {CW{1'b0}};
            if (cur_row_s == RW'(IMG_HEIGHT - 1)) begin
                next_row_s = {RW{1'b0}};
            end else begin
                next_row_s = cur_row_s + RW'(1);
            end
        end else begin
            next_col_s = cur_col_s + CW'(1);
            next_row_s = cur_row_s;
        end
        lb1_rd_s = lb1_r[cur_col_s];
        lb2_rd_s = lb2_r[cur_col_s];
        // Each row shifts toward the low (oldest column) end; new column enters on top.
        win_next_s = {i_pixel,  win_r[3*FW-1 -: 2*NB_DATA],
                      lb1_rd_s, win_r[2*FW-1 -: 2*NB_DATA],
                      lb2_rd_s, win_r[FW-1   -: 2*NB_DATA]};
        // Row/column thresholds keep windows inside one frame and one row.
        win_ok_s = (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
    end

    // Counters, window shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            col_r      <= {CW{1'b0}};
            row_r      <= {RW{1'b0}};
            win_r      <= {WW{1'b0}};
            o_window_r <= {WW{1'b0}};
            o_valid_r  <= 1'b0;
        end else if (i_valid) begin
            col_r     <= next_col_s;
            row_r     <= next_row_s;
            win_r     <= win_next_s;
            o_valid_r <= win_ok_s;
            if (win_ok_s) begin
                o_window_r <= win_next_s;
            end else begin
                o_window_r <= o_window_r;
            end
        end else begin
            o_valid_r <= 1'b0;
        end
    end

    // Line buffers age one row per accepted pixel; contents need no reset.
    always_ff @(posedge clk) begin
        if (i_rst && i_valid) begin
            lb2_r[cur_col_s] <= lb1_r[cur_col_s];
            lb1_r[cur_col_s] <= i_pixel;
        end
    end

    assign o_window = o_window_r;
    assign o_valid  = o_valid_r;

endmodule
